// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: FSM state encodings.
package uart_tx_arbiter_pkg;

    typedef logic [1:0] arb_state_t;

    localparam logic [1:0] ST_ARB       = 2'd0;
    localparam logic [1:0] ST_START     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: the first valid requester after ptr,
// wrapping modulo NUM_REQ, is granted (one-hot plus index).
module uart_tx_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan from ptr+1 upward, wrapping; the first valid requester wins.
    always_comb begin
        grant    = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(ptr) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && valid[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte-stream requesters.
// Round-robin per frame (or per byte when FRAME_LOCK=0); each launch is a
// start pulse followed by busy-rise and busy-fall tracking with a timeout.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_BITS    = 8,
    parameter int FRAME_LOCK   = 1,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx_start,
    output logic [DATA_BITS-1:0]         tx_data,
    input  logic                         tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         frame_active,
    output logic                         err_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT);

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;
    logic             last_q;
    logic [CNT_W-1:0] cnt;

    logic [NUM_REQ-1:0]   owner_mask;
    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   pick_grant;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_found;
    logic [DATA_BITS-1:0] pick_byte;

    // While a frame is locked only its owner may compete.
    always_comb begin
        owner_mask        = '0;
        owner_mask[owner] = 1'b1;
        eligible          = frame_active ? (req_valid & owner_mask) : req_valid;
        pick_byte         = req_data[pick_idx*DATA_BITS +: DATA_BITS];
    end

    uart_tx_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .valid (eligible),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Launch sequencer: accept, pulse start, wait for busy to rise then fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_ARB;
            ptr          <= IDX_W'(NUM_REQ - 1);
            owner        <= '0;
            last_q       <= 1'b0;
            cnt          <= '0;
            req_ready    <= '0;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            grant_id     <= '0;
            frame_active <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            req_ready   <= '0;
            tx_start    <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                ST_ARB: begin
                    // An externally busy transmitter blocks any new accept.
                    if (!tx_busy && pick_found) begin
                        req_ready <= pick_grant;
                        tx_data   <= pick_byte;
                        last_q    <= req_last[pick_idx];
                        grant_id  <= pick_idx;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    tx_start <= 1'b1;
                    cnt      <= '0;
                    state    <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        // Transmitter never took the byte: drop it and release the lock.
                        err_timeout  <= 1'b1;
                        frame_active <= 1'b0;
                        ptr          <= grant_id;
                        state        <= ST_ARB;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= ST_ARB;
                        if (FRAME_LOCK != 0 && !last_q) begin
                            frame_active <= 1'b1;
                            owner        <= grant_id;
                        end else begin
                            frame_active <= 1'b0;
                            ptr          <= grant_id;
                        end
                    end
                end
                default: state <= ST_ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (frame lock on / off), each with
// byte-queue requesters, a transmitter model and a launch scoreboard.
module tb_uart_tx_arbiter;

    localparam int NR       = 4;
    localparam int DB       = 8;
    localparam int BUSY_LEN = 4;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] d;
        logic       fa;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] id, input logic [7:0] d, input logic fa);
        exp_t e;
        e.id = id;
        e.d  = d;
        e.fa = fa;
        return e;
    endfunction

    for (genvar u = 0; u < 2; u++) begin : g_unit
        logic [NR-1:0]    req_valid = '0;
        logic [NR-1:0]    req_last  = '0;
        logic [NR*DB-1:0] req_data  = '0;
        logic             tx_busy   = 1'b0;
        logic [NR-1:0]    req_ready;
        logic             tx_start;
        logic [DB-1:0]    tx_data;
        logic [1:0]       grant_id;
        logic             frame_active;
        logic             err_timeout;
        logic [8:0]       rq [NR][$];
        exp_t             sb [$];
        int               busy_cnt  = 0;
        int               stub_skip = 0;
        logic             fa_seen   = 1'b0;

        uart_tx_arbiter #(
            .NUM_REQ      (NR),
            .DATA_BITS    (DB),
            .FRAME_LOCK   ((u == 0) ? 1 : 0),
            .BUSY_TIMEOUT (16)
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .req_valid    (req_valid),
            .req_data     (req_data),
            .req_last     (req_last),
            .req_ready    (req_ready),
            .tx_start     (tx_start),
            .tx_data      (tx_data),
            .tx_busy      (tx_busy),
            .grant_id     (grant_id),
            .frame_active (frame_active),
            .err_timeout  (err_timeout)
        );

        // Requesters: present the head of each byte queue, pop on accept.
        always @(negedge clk) begin
            for (int i = 0; i < NR; i++) begin
                if (req_ready[i] && req_valid[i] && rq[i].size() > 0)
                    void'(rq[i].pop_front());
                if (rq[i].size() > 0) begin
                    req_valid[i]         = 1'b1;
                    req_data[i*DB +: DB] = rq[i][0][7:0];
                    req_last[i]          = rq[i][0][8];
                end else begin
                    req_valid[i]         = 1'b0;
                    req_data[i*DB +: DB] = '0;
                    req_last[i]          = 1'b0;
                end
            end
        end

        // Transmitter model and launch scoreboard.
        always @(negedge clk) begin
            exp_t e;
            if (frame_active === 1'b1) fa_seen = 1'b1;
            if (rst) begin
                busy_cnt = 0;
                tx_busy  = 1'b0;
            end else begin
                if (tx_start) begin
                    check_eq($sformatf("u%0d_start_while_busy", u), 32'(tx_busy), 0);
                    check_eq($sformatf("u%0d_start_expected", u), 32'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check_eq($sformatf("u%0d_tx_data", u), 32'(tx_data), 32'(e.d));
                        check_eq($sformatf("u%0d_grant_id", u), 32'(grant_id), 32'(e.id));
                        check_eq($sformatf("u%0d_frame_active", u), 32'(frame_active), 32'(e.fa));
                    end
                    if (stub_skip > 0) stub_skip--;
                    else busy_cnt = BUSY_LEN;
                end
                if (busy_cnt > 0) begin
                    tx_busy = 1'b1;
                    busy_cnt--;
                end else begin
                    tx_busy = 1'b0;
                end
            end
        end
    end

    function automatic bit all_idle();
        bit idle = 1'b1;
        if (g_unit[0].sb.size() != 0 || g_unit[1].sb.size() != 0) idle = 1'b0;
        if (g_unit[0].tx_busy || g_unit[1].tx_busy) idle = 1'b0;
        for (int i = 0; i < NR; i++)
            if (g_unit[0].rq[i].size() != 0 || g_unit[1].rq[i].size() != 0) idle = 1'b0;
        return idle;
    endfunction

    task automatic drain(input string tag);
        bit done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            done = all_idle();
        end
        check_eq({tag, "_drain"}, 32'(done), 1);
        repeat (6) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_ready"}, 32'(g_unit[0].req_ready), 0);
        check_eq({tag, "_start"}, 32'(g_unit[0].tx_start), 0);
        check_eq({tag, "_data"}, 32'(g_unit[0].tx_data), 0);
        check_eq({tag, "_grant"}, 32'(g_unit[0].grant_id), 0);
        check_eq({tag, "_fa"}, 32'(g_unit[0].frame_active), 0);
        check_eq({tag, "_err"}, 32'(g_unit[0].err_timeout), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int cnt;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Single byte from requester 0
        g_unit[0].sb.push_back(mk(2'd0, 8'hA5, 1'b0));
        g_unit[0].rq[0].push_back({1'b1, 8'hA5});
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (g_unit[0].req_ready != 0) found = 1'b1;
        end
        check_eq("t1_ready_seen", 32'(found), 1);
        check_eq("t1_ready_onehot", 32'(g_unit[0].req_ready), 32'h1);
        @(negedge clk);
        check_eq("t1_ready_single", 32'(g_unit[0].req_ready), 0);
        check_eq("t1_start_latency", 32'(g_unit[0].tx_start), 1);
        drain("t1");
        check_eq("t1_fa_idle", 32'(g_unit[0].frame_active), 0);

        // Three requesters, single-byte frames: order 0,1,2,0,1
        do_reset();
        g_unit[0].sb.push_back(mk(2'd0, 8'h10, 1'b0));
        g_unit[0].sb.push_back(mk(2'd1, 8'h20, 1'b0));
        g_unit[0].sb.push_back(mk(2'd2, 8'h30, 1'b0));
        g_unit[0].sb.push_back(mk(2'd0, 8'h40, 1'b0));
        g_unit[0].sb.push_back(mk(2'd1, 8'h50, 1'b0));
        g_unit[0].rq[0].push_back({1'b1, 8'h10});
        g_unit[0].rq[0].push_back({1'b1, 8'h40});
        g_unit[0].rq[1].push_back({1'b1, 8'h20});
        g_unit[0].rq[1].push_back({1'b1, 8'h50});
        g_unit[0].rq[2].push_back({1'b1, 8'h30});
        drain("t2");

        // Locked three-byte frame from requester 1 while requester 0 waits
        do_reset();
        g_unit[0].sb.push_back(mk(2'd1, 8'h11, 1'b0));
        g_unit[0].sb.push_back(mk(2'd1, 8'h22, 1'b1));
        g_unit[0].sb.push_back(mk(2'd1, 8'h33, 1'b1));
        g_unit[0].sb.push_back(mk(2'd0, 8'h44, 1'b0));
        g_unit[0].rq[1].push_back({1'b0, 8'h11});
        g_unit[0].rq[1].push_back({1'b0, 8'h22});
        g_unit[0].rq[1].push_back({1'b1, 8'h33});
        repeat (3) @(negedge clk);
        g_unit[0].rq[0].push_back({1'b1, 8'h44});
        drain("t3");
        check_eq("t3_fa_released", 32'(g_unit[0].frame_active), 0);

        // Busy never rises for the first launch: timeout then next requester
        do_reset();
        g_unit[0].stub_skip = 1;
        g_unit[0].sb.push_back(mk(2'd0, 8'h55, 1'b0));
        g_unit[0].sb.push_back(mk(2'd1, 8'h66, 1'b0));
        g_unit[0].rq[0].push_back({1'b1, 8'h55});
        g_unit[0].rq[1].push_back({1'b1, 8'h66});
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (g_unit[0].tx_start) found = 1'b1;
        end
        check_eq("t4_start_seen", 32'(found), 1);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!g_unit[0].err_timeout && cnt < 40);
        check_eq("t4_timeout_latency", 32'(cnt), 16);
        @(negedge clk);
        check_eq("t4_err_single", 32'(g_unit[0].err_timeout), 0);
        drain("t4");

        // Asynchronous reset while waiting for busy to fall
        do_reset();
        g_unit[0].sb.push_back(mk(2'd2, 8'h77, 1'b0));
        g_unit[0].rq[2].push_back({1'b1, 8'h77});
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (g_unit[0].tx_busy) found = 1'b1;
        end
        check_eq("t5_busy_seen", 32'(found), 1);
        @(posedge clk);
        #2;
        check_eq("t5_pre_grant", 32'(g_unit[0].grant_id), 2);
        rst = 1'b1;
        #1;
        check_zero("t5_async");
        g_unit[0].sb.push_back(mk(2'd0, 8'h88, 1'b0));
        g_unit[0].sb.push_back(mk(2'd3, 8'h99, 1'b0));
        g_unit[0].rq[0].push_back({1'b1, 8'h88});
        g_unit[0].rq[3].push_back({1'b1, 8'h99});
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        drain("t5");

        // No frame lock: two-byte frame from 1 interleaves with 2
        do_reset();
        g_unit[1].sb.push_back(mk(2'd1, 8'hA1, 1'b0));
        g_unit[1].sb.push_back(mk(2'd2, 8'hB1, 1'b0));
        g_unit[1].sb.push_back(mk(2'd1, 8'hA2, 1'b0));
        g_unit[1].rq[1].push_back({1'b0, 8'hA1});
        g_unit[1].rq[1].push_back({1'b1, 8'hA2});
        g_unit[1].rq[2].push_back({1'b1, 8'hB1});
        drain("t6");
        check_eq("t6_fa_never", 32'(g_unit[1].fa_seen), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
